// File: rtl/instr_mem_loader_if.sv
// Byte-stream in / instruction-memory write out bundle for instr_mem_loader.
// master = loader side, slave = stream source + memory side.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 7
);
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  byte_data, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output byte_data, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Assembles little-endian words from a byte stream, writes them to imem, pads the rest with NOP.
// Optional LOADER_CHECKSUM_EN: trailing 32-bit checksum word compared against the modular sum of data words.
module instr_mem_loader #(
  parameter int          DEPTH    = 128,
  parameter int          ADDR_W   = 7,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [ADDR_W:0]     word_count_i,
  instr_mem_loader_if.master  bus,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o
);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, FILL, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t          state_q, state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [ADDR_W:0] idx_q, idx_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [31:0]     word_q, word_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            can_start, start_ok, start_bad, byte_acc, last_byte;
  logic [ADDR_W:0] idx_inc;

`ifdef LOADER_CHECKSUM_EN
  logic            cks_phase_q, cks_phase_d;
  logic            cks_bad_q, cks_bad_d;
  logic [31:0]     sum_q, sum_d;
`endif

  assign can_start = (state_q == IDLE) || (state_q == DONE);
  assign start_ok  = can_start && start_i && (word_count_i <= DEPTH_C);
  assign start_bad = can_start && start_i && (word_count_i >  DEPTH_C);
  assign byte_acc  = (state_q == RECV) && bus.byte_valid;
  assign last_byte = byte_acc && (byte_cnt_q == 2'd3);
  assign idx_inc   = idx_q + ONE_C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_bad) begin
          state_d = DONE;
        end else if (start_ok) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = RECV;
`else
          state_d = (word_count_i == '0) ? FILL : RECV;
`endif
        end
      end
      RECV: begin
        if (last_byte) begin
`ifdef LOADER_CHECKSUM_EN
          if (cks_phase_q) state_d = (count_q == DEPTH_C) ? DONE : FILL;
          else             state_d = WRITE;
`else
          state_d = WRITE;
`endif
        end
      end
      WRITE: begin
        if (idx_inc == count_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = RECV;
`else
          state_d = (count_q == DEPTH_C) ? DONE : FILL;
`endif
        end else begin
          state_d = RECV;
        end
      end
      FILL: begin
        if (idx_q == LAST_C) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.byte_ready = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = idx_q[ADDR_W-1:0];
    bus.mem_wdata  = word_q;
    busy_o         = 1'b0;
    case (state_q)
      RECV: begin
        bus.byte_ready = 1'b1;
        busy_o         = 1'b1;
      end
      WRITE: begin
        bus.mem_we = 1'b1;
        busy_o     = 1'b1;
      end
      FILL: begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = NOP_WORD;
        busy_o        = 1'b1;
      end
      default: ;
    endcase
  end

  assign done_o  = done_q;
  assign error_o = error_q;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    idx_d      = idx_q;
    count_d    = count_q;
    word_d     = word_q;
    done_d     = done_q;
    error_d    = error_q;
`ifdef LOADER_CHECKSUM_EN
    cks_phase_d = cks_phase_q;
    cks_bad_d   = cks_bad_q;
    sum_d       = sum_q;
`endif

    if (start_ok) begin
      count_d    = word_count_i;
      idx_d      = '0;
      byte_cnt_d = 2'd0;
      done_d     = 1'b0;
      error_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      cks_phase_d = (word_count_i == '0);
      cks_bad_d   = 1'b0;
      sum_d       = '0;
`endif
    end

    if (byte_acc) begin
      word_d[8*byte_cnt_q +: 8] = bus.byte_data;
      byte_cnt_d                = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
      if (last_byte && cks_phase_q) begin
        cks_bad_d   = ({bus.byte_data, word_q[23:0]} != sum_q);
        cks_phase_d = 1'b0;
      end
`endif
    end

    if (state_q == WRITE) begin
      idx_d = idx_inc;
`ifdef LOADER_CHECKSUM_EN
      sum_d = sum_q + word_q;
      if (idx_inc == count_q) cks_phase_d = 1'b1;
`endif
    end

    if (state_q == FILL) idx_d = idx_inc;

    // done/error latch on entry to DONE; a bad start while in DONE re-asserts error there
    if (start_bad) begin
      done_d  = 1'b1;
      error_d = 1'b1;
    end else if ((state_d == DONE) && (state_q != DONE)) begin
      done_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      error_d = error_d | cks_bad_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= 2'd0;
      idx_q      <= '0;
      count_q    <= '0;
      word_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      cks_phase_q <= 1'b0;
      cks_bad_q   <= 1'b0;
      sum_q       <= '0;
`endif
    end else begin
      byte_cnt_q <= byte_cnt_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      word_q     <= word_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
      cks_phase_q <= cks_phase_d;
      cks_bad_q   <= cks_bad_d;
      sum_q       <= sum_d;
`endif
    end
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Write-side counterpart of the instruction memory's read port. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written to consecutive word addresses of the 128-entry instruction memory, and all remaining entries are padded with NOP. It sits between the testbench/boot source and the instruction memory write port, and runs before the core is released from reset.

Parameters:
DEPTH, 128, number of 32-bit words in instruction memory
ADDR_W, 7, word-address width (log2 DEPTH)
NOP_WORD, 32'h00000013, pad value (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a load; sampled only in IDLE
word_count  in  ADDR_W+1  number of words to load; latched on start
byte_data  in  8  stream byte
byte_valid  in  1  byte_data valid
byte_ready  out  1  loader can accept a byte
mem_we  out  1  instruction memory write enable
mem_addr  out  ADDR_W  word address (memory byte address = mem_addr<<2)
mem_wdata  out  32  word to write
busy  out  1  load in progress (state not IDLE/DONE)
done  out  1  load finished; held until next accepted start
error  out  1  load failed; held until next accepted start

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE; byte_ready, mem_we, busy, done, error = 0; mem_addr=0; mem_wdata=0; byte and word counters = 0.
- States: IDLE, RECV, WRITE, FILL, DONE.
- IDLE: on start=1:
  - if word_count > DEPTH, set error=1 and go to DONE with no writes;
  - otherwise latch word_count, clear done/error, set word index=0, and go to RECV; if word_count==0, go straight to FILL.
- RECV: byte_ready=1. A byte is accepted on a rising edge with byte_valid && byte_ready.
  - Byte k (0..3) fills bits [8k+7:8k] (little-endian).
  - After the 4th accepted byte, go to WRITE.
  - A byte_valid=0 gap holds state indefinitely.
- WRITE: exactly one cycle; byte_ready=0, mem_we=1, mem_addr=word index, mem_wdata=assembled word.
  - Next: word index+1. If that equals the latched count, go to FILL; else go to RECV with byte counter=0.
- FILL: one NOP_WORD write per cycle (mem_we=1) at addresses count..DEPTH-1, then go to DONE.
  - If count==DEPTH, FILL takes zero cycles and WRITE goes directly to DONE.
- DONE: done=1 (level), busy=0, byte_ready=0. Return to IDLE-equivalent behaviour: a new start is accepted here exactly as in IDLE.
- start while busy is ignored. Bytes offered outside RECV are not accepted (byte_ready=0).
- Throughput: 5 cycles minimum per word (4 accept + 1 write).
- Reset mid-load: returns to IDLE immediately and discards the partial word. Memory contents already written are untouched (this block never resets memory).
- mem_addr wraps never: the index is bounded by the count check.

Optional Feature:
LOADER_CHECKSUM_EN
- With the macro defined: after the last data word, RECV accepts 4 more bytes forming a checksum word; these bytes are not written.
  - The loader keeps a running 32-bit modular sum (carry discarded) of all data words.
  - If checksum != sum, error=1 on entering DONE. FILL still executes.
- Without the macro: no checksum phase; error is driven only by the word_count > DEPTH check.

Test Plan:
- Reset then start, word_count=2, bytes 13,05,10,00,B3,02,52,00 -> writes addr0=00100513, addr1=005202B3; then 126 NOP writes at addr2..127; then done=1, error=0.
- word_count=0 -> no byte_ready; 128 consecutive NOP writes at addr0..127; done=1 after 128 write cycles.
- word_count=129 -> error=1, done=1, mem_we never asserted.
- byte_valid toggling 1,0,0,1 per cycle during RECV -> same words written; mem_we only in WRITE/FILL; no byte lost or duplicated.
- rst_n low after 6 accepted bytes (word 1 partial) -> all outputs at reset values asynchronously; new start with word_count=1 writes addr0 correctly from fresh bytes.
- With LOADER_CHECKSUM_EN, words 00000001,00000002, checksum 00000003 -> error=0; same stream with checksum 00000004 -> error=1, done=1.
